// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared single-port memory
//
// Purpose: lets the core and the debug/loader port take turns on the single-port
// unified memory. The arbiter accepts one winning request in IDLE and drives the
// memory for one cycle in ISSUE. In RESP it pulses the winner's ack while rdata is valid.
// Option: define ARB_ROUND_ROBIN_EN for round-robin arbitration. Leave it undefined
// for fixed priority, where the core always wins.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   core_req/we/addr/wdata  core request (held until core_ack)
//   core_ack, core_stall    core completion pulse, combinational stall
//   dbg_req/we/addr/wdata   debug request (held until dbg_ack)
//   dbg_ack                 debug completion pulse
//   rdata                   read data, valid in the ack cycle
//   mem_en/we/addr/wdata    registered memory controls
//   mem_rdata               synchronous memory read data

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;           // 0 = core, 1 = debug
  logic              last_owner_q, last_owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              grant_dbg;

`ifdef ARB_ROUND_ROBIN_EN
  // Under contention the port that was not served last wins.
  assign grant_dbg = dbg_req & (~core_req | ~last_owner_q);
`else
  // Fixed priority: debug is served only while the core is not asking.
  assign grant_dbg = dbg_req & ~core_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (core_req || dbg_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          owner_d  = grant_dbg;
          if (grant_dbg) begin
            mem_we_d    = dbg_we;
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
          end else begin
            mem_we_d    = core_we;
            mem_addr_d  = core_addr;
            mem_wdata_d = core_wdata;
          end
        end
      end
      ISSUE: begin
        // The memory samples the captured access at the end of this cycle.
        state_d  = RESP;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
      RESP: begin
        state_d      = IDLE;
        last_owner_d = owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign core_ack   = (state_q == RESP) & ~owner_q;
  assign dbg_ack    = (state_q == RESP) &  owner_q;
  assign core_stall = core_req & ~core_ack;
  assign rdata      = mem_rdata;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_ack, core_stall, dbg_ack;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // Memory macro stand-in plus an independent reference copy of its contents.
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic bd_write(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx[7:0]; bd_data = data;
    ref_mem[idx] = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One request on one port; returns read data, ack latency (-1 on timeout)
  // and the number of cycles core_stall was high.
  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] data,
                           output int lat, output int stall_cyc);
    @(negedge clk);
    if (port) begin dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1; end
    else      begin core_we = we; core_addr = addr; core_wdata = wdata; core_req = 1'b1; end
    #1;
    stall_cyc = core_stall ? 1 : 0;
    lat = -1;
    data = 'x;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if ((port && dbg_ack) || (!port && core_ack)) begin
        lat = c; data = rdata; break;
      end
      if (core_stall) stall_cyc++;
    end
    @(negedge clk);
    core_req = 1'b0; dbg_req = 1'b0;
  endtask

  task automatic test_reset();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    reset = 1'b0;
    for (int i = 0; i < 256; i++) bd_write(i, $urandom);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, core_ack, dbg_ack, core_stall} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {mem_en, mem_we, core_ack, dbg_ack, core_stall});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_regs got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_core_read();
    bd_write(4, 32'h1234ABCD);
    @(negedge clk);
    core_we = 0; core_addr = 32'h10; core_req = 1'b1;
    #1;
    checks++;
    if (core_stall !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL rd_c0 got stall=%b en=%b want 1 0", core_stall, mem_en);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h10 || core_ack !== 1'b0 || core_stall !== 1'b1) begin
      errors++; $display("FAIL rd_issue got en=%b addr=%h ack=%b stall=%b want 1 10 0 1",
                         mem_en, mem_addr, core_ack, core_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_en !== 1'b0 || core_ack !== 1'b1 || core_stall !== 1'b0 || rdata !== 32'h1234ABCD) begin
      errors++; $display("FAIL rd_resp got en=%b ack=%b stall=%b rdata=%h want 0 1 0 1234abcd",
                         mem_en, core_ack, core_stall, rdata);
    end
    @(negedge clk);
    core_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (core_ack !== 1'b0 || dbg_ack !== 1'b0) begin
      errors++; $display("FAIL rd_ack_width got core_ack=%b dbg_ack=%b want 0 0", core_ack, dbg_ack);
    end
  endtask

  task automatic test_dbg_write();
    logic [31:0] d;
    int lat, st;
    do_access(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, d, lat, st);
    ref_mem[16] = 32'hDEADBEEF;
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL dbg_wr_lat got %0d want 2", lat); end
    do_access(1'b0, 1'b0, 32'h40, 32'h0, d, lat, st);
    checks++;
    if (lat !== 2 || d !== ref_mem[16]) begin
      errors++; $display("FAIL dbg_wr_readback got lat=%0d data=%h want 2 %h", lat, d, ref_mem[16]);
    end
    checks++;
    if (st !== 2) begin errors++; $display("FAIL core_stall_len got %0d want 2", st); end
  endtask

  task automatic test_contention();
    bit exp_port [$];
    int c_left = 2, d_left = 2, idx = 0;
    bit last = 1'b1;
    bit drop_c, drop_d;
    // Expected grant order from the arbitration rule alone.
    while (c_left > 0 || d_left > 0) begin
      bit pick;
      if (c_left > 0 && d_left > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick = ~last;
`else
        pick = 1'b0;
`endif
      end else pick = (d_left > 0);
      exp_port.push_back(pick);
      last = pick;
      if (pick) d_left--; else c_left--;
    end
    c_left = 2; d_left = 2;
    apply_reset();
    @(negedge clk);
    core_we = 0; core_addr = 32'h0; core_req = 1'b1;
    dbg_we = 0;  dbg_addr = 32'h4;  dbg_req = 1'b1;
    for (int cyc = 1; cyc <= 20 && idx < 4; cyc++) begin
      @(posedge clk); #1;
      drop_c = 0; drop_d = 0;
      if (core_ack && dbg_ack) begin
        checks++; errors++; $display("FAIL both_acks at cycle %0d", cyc);
      end else if (core_ack || dbg_ack) begin
        checks++;
        if (dbg_ack !== exp_port[idx] || cyc != 2 + 3 * idx || rdata !== ref_mem[dbg_ack ? 1 : 0]) begin
          errors++; $display("FAIL contend_%0d got port=%b cyc=%0d data=%h want %b %0d %h", idx,
                             dbg_ack, cyc, rdata, exp_port[idx], 2 + 3 * idx, ref_mem[exp_port[idx] ? 1 : 0]);
        end
        if (dbg_ack) begin d_left--; drop_d = (d_left == 0); end
        else         begin c_left--; drop_c = (c_left == 0); end
        idx++;
      end
      @(negedge clk);
      if (drop_c) core_req = 1'b0;
      if (drop_d) dbg_req = 1'b0;
    end
    core_req = 1'b0; dbg_req = 1'b0;
    checks++;
    if (idx != 4) begin errors++; $display("FAIL contend_count got %0d want 4", idx); end
  endtask

  task automatic test_back_to_back();
    int widx [3];
    int n = 0, en_cnt = 0, last_ack = -10;
    for (int i = 0; i < 3; i++) widx[i] = 64 + $urandom_range(0, 63);
    @(negedge clk);
    core_we = 0; core_addr = widx[0] * 4; core_req = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      if (mem_en) en_cnt++;
      if (core_ack) begin
        checks++;
        if (cyc != 2 + 3 * n || cyc - last_ack < 2 || rdata !== ref_mem[widx[n]]) begin
          errors++; $display("FAIL b2b_%0d got cyc=%0d data=%h want %0d %h", n, cyc, rdata,
                             2 + 3 * n, ref_mem[widx[n]]);
        end
        last_ack = cyc;
        n++;
        @(negedge clk);
        if (n == 3) core_req = 1'b0;
        else core_addr = widx[n] * 4;
      end
    end
    core_req = 1'b0;
    checks++;
    if (n != 3 || en_cnt != 3) begin
      errors++; $display("FAIL b2b_count got acks=%0d mem_en=%0d want 3 3", n, en_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int lat, st;
    bit saw = 0;
    logic [31:0] newv;
    newv = ref_mem[32] ^ $urandom ^ 32'h1;
    @(negedge clk);
    dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = newv; dbg_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL rst_mid_issue got en=%b we=%b want 1 1", mem_en, mem_we);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async got en=%b we=%b want 0 0", mem_en, mem_we);
    end
    if (dbg_ack) saw = 1;
    @(negedge clk);
    dbg_req = 1'b0; dbg_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (dbg_ack) saw = 1; end
    checks++;
    if (saw) begin errors++; $display("FAIL rst_mid_noack got dbg_ack=1 want 0"); end
    do_access(1'b0, 1'b0, 32'h80, 32'h0, d, lat, st);
    checks++;
    if (lat !== 2 || d !== ref_mem[32]) begin
      errors++; $display("FAIL rst_mid_mem got lat=%0d data=%h want 2 %h", lat, d, ref_mem[32]);
    end
  endtask

  task automatic test_addr_change();
    bd_write(9, ref_mem[8] ^ 32'h5A5A0001);
    @(negedge clk);
    core_we = 0; core_addr = 32'h20; core_req = 1'b1;
    @(posedge clk); #1;
    core_addr = 32'h24;
    checks++;
    if (mem_addr !== 32'h20) begin errors++; $display("FAIL addr_hold got %h want 00000020", mem_addr); end
    @(posedge clk); #1;
    checks++;
    if (core_ack !== 1'b1 || rdata !== ref_mem[8]) begin
      errors++; $display("FAIL addr_change got ack=%b data=%h want 1 %h", core_ack, rdata, ref_mem[8]);
    end
    @(negedge clk);
    core_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_dbg_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_addr_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
